// File: rtl/lcd_mode_ctrl_pkg.sv
// Shared timing constants, mode encoding and mode decode helper for the
// LCD mode controller.
package lcd_mode_ctrl_pkg;

  localparam int unsigned DOTS_PER_LINE   = 456;
  localparam int unsigned LINES_PER_FRAME = 154;
  localparam int unsigned VISIBLE_LINES   = 144;
  localparam int unsigned OAM_DOTS        = 80;
  localparam int unsigned XFER_DOTS       = 172;

  // Derived counter boundaries, sized to the counter widths.
  localparam logic [8:0] X_LAST       = 9'(DOTS_PER_LINE - 1);
  localparam logic [7:0] V_LAST       = 8'(LINES_PER_FRAME - 1);
  localparam logic [7:0] V_VBLANK     = 8'(VISIBLE_LINES);
  localparam logic [8:0] X_OAM_END    = 9'(OAM_DOTS);
  localparam logic [8:0] X_XFER_END   = 9'(OAM_DOTS + XFER_DOTS);
  // Last OAM-search dot: VRAM is handed to the display one dot early so an
  // in-flight CPU access finishes before transfer starts.
  localparam logic [8:0] X_VRAM_GUARD = 9'(OAM_DOTS - 1);

  // STAT interrupt enable bit positions.
  localparam int unsigned STAT_IE_HBLANK = 0;
  localparam int unsigned STAT_IE_VBLANK = 1;
  localparam int unsigned STAT_IE_OAM    = 2;
  localparam int unsigned STAT_IE_LYC    = 3;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_XFER   = 2'd3
  } lcd_mode_t;

  // Mode implied by a dot/line position.
  function automatic lcd_mode_t decode_mode(input logic [8:0] x, input logic [7:0] v);
    lcd_mode_t m;
    if (v >= V_VBLANK) begin
      m = MODE_VBLANK;
    end else if (x < X_OAM_END) begin
      m = MODE_OAM;
    end else if (x < X_XFER_END) begin
      m = MODE_XFER;
    end else begin
      m = MODE_HBLANK;
    end
    return m;
  endfunction

endpackage

// File: rtl/lcd_mode_ctrl_stat_irq.sv
// STAT interrupt generator: ORs the enabled mode/LYC sources into the STAT
// line, registers it, and pulses lcdc_int_o only on its rising edge so a line
// held high across a mode change does not retrigger.
module lcd_stat_irq
  import lcd_mode_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      enable_i,
  input  lcd_mode_t mode_i,
  input  logic      lyc_match_i,
  input  logic [3:0] stat_ie_i,
  output logic      lcdc_int_o
);

  logic stat_line_d;
  logic stat_line_q;
  logic lcdc_int_q;

  // Combine enabled interrupt sources; the line is forced low while disabled.
  always_comb begin
    stat_line_d = 1'b0;
    if (enable_i) begin
      stat_line_d = (stat_ie_i[STAT_IE_HBLANK] && (mode_i == MODE_HBLANK)) ||
                    (stat_ie_i[STAT_IE_VBLANK] && (mode_i == MODE_VBLANK)) ||
                    (stat_ie_i[STAT_IE_OAM]    && (mode_i == MODE_OAM))    ||
                    (stat_ie_i[STAT_IE_LYC]    && lyc_match_i);
    end else begin
      stat_line_d = 1'b0;
    end
  end

  // Register the STAT line and emit a one-cycle pulse on its 0->1 edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_line_q <= 1'b0;
      lcdc_int_q  <= 1'b0;
    end else begin
      stat_line_q <= stat_line_d;
      lcdc_int_q  <= stat_line_d & ~stat_line_q;
    end
  end

  assign lcdc_int_o = lcdc_int_q;

endmodule

// File: rtl/lcd_mode_ctrl.sv
// LCD mode controller: dot/line counters, registered mode decode, LY/LYC
// compare, VBLANK pulse, STAT interrupt, and CPU/display arbitration of
// VRAM and OAM.
module lcd_mode_ctrl
  import lcd_mode_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_en,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_ie,
  input  logic       cpu_vram_req,
  input  logic       cpu_oam_req,
  input  logic       disp_vram_req,
  input  logic       disp_oam_req,
  output logic       cpu_vram_gnt,
  output logic       cpu_oam_gnt,
  output logic       oe_vram,
  output logic       oe_oam,
  output logic [1:0] mode,
  output logic [7:0] lcd_v,
  output logic [8:0] lcd_x,
  output logic       lyc_match,
  output logic       vblank_int,
  output logic       lcdc_int
);

  // en_q marks that the counters are running; it distinguishes the first
  // enabled cycle (counters restart at 0) from normal counting.
  logic       en_d,         en_q;
  logic [8:0] x_d,          x_q;
  logic [7:0] v_d,          v_q;
  lcd_mode_t  mode_d,       mode_q;
  logic       lyc_match_d,  lyc_match_q;
  logic       vblank_int_d, vblank_int_q;
  // Low only in the cycle(s) following a reset edge; keeps CPU grants at 0
  // there, since grants are otherwise combinational from the requests.
  logic       out_ok_q;

  logic       lock_oam_s;
  logic       lock_vram_s;
  logic       stat_en_s;

  // Next counter values and the mode/compare/VBLANK state derived from them.
  always_comb begin
    en_d         = 1'b0;
    x_d          = 9'd0;
    v_d          = 8'd0;
    mode_d       = MODE_HBLANK;
    lyc_match_d  = 1'b0;
    vblank_int_d = 1'b0;
    if (lcd_en) begin
      en_d = 1'b1;
      if (!en_q) begin
        x_d = 9'd0;
        v_d = 8'd0;
      end else if (x_q == X_LAST) begin
        x_d = 9'd0;
        if (v_q == V_LAST) begin
          v_d = 8'd0;
        end else begin
          v_d = v_q + 8'd1;
        end
      end else begin
        x_d = x_q + 9'd1;
        v_d = v_q;
      end
      mode_d       = decode_mode(x_d, v_d);
      lyc_match_d  = (v_d == lyc);
      vblank_int_d = (x_d == 9'd0) && (v_d == V_VBLANK);
    end else begin
      en_d = 1'b0;
    end
  end

  // Counter, mode and status registers; reset has priority over enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q         <= 1'b0;
      x_q          <= 9'd0;
      v_q          <= 8'd0;
      mode_q       <= MODE_HBLANK;
      lyc_match_q  <= 1'b0;
      vblank_int_q <= 1'b0;
      out_ok_q     <= 1'b0;
    end else begin
      en_q         <= en_d;
      x_q          <= x_d;
      v_q          <= v_d;
      mode_q       <= mode_d;
      lyc_match_q  <= lyc_match_d;
      vblank_int_q <= vblank_int_d;
      out_ok_q     <= 1'b1;
    end
  end

  // Display lock windows from the registered mode and dot position.
  always_comb begin
    lock_oam_s  = 1'b0;
    lock_vram_s = 1'b0;
    case (mode_q)
      MODE_OAM: begin
        lock_oam_s  = 1'b1;
        lock_vram_s = (x_q == X_VRAM_GUARD);
      end
      MODE_XFER: begin
        lock_oam_s  = 1'b1;
        lock_vram_s = 1'b1;
      end
      MODE_HBLANK, MODE_VBLANK: begin
        lock_oam_s  = 1'b0;
        lock_vram_s = 1'b0;
      end
      default: begin
        lock_oam_s  = 1'b0;
        lock_vram_s = 1'b0;
      end
    endcase
  end

  // The STAT line is only live while counting and still enabled, so neither
  // the enabling nor the disabling edge can produce a spurious pulse.
  assign stat_en_s = en_q & lcd_en;

  lcd_stat_irq u_stat_irq (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (stat_en_s),
    .mode_i      (mode_q),
    .lyc_match_i (lyc_match_q),
    .stat_ie_i   (stat_ie),
    .lcdc_int_o  (lcdc_int)
  );

  assign cpu_oam_gnt  = cpu_oam_req  & ~lock_oam_s  & out_ok_q;
  assign cpu_vram_gnt = cpu_vram_req & ~lock_vram_s & out_ok_q;
  assign oe_oam       = disp_oam_req  & lock_oam_s;
  assign oe_vram      = disp_vram_req & lock_vram_s;

  assign mode       = mode_q;
  assign lcd_v      = v_q;
  assign lcd_x      = x_q;
  assign lyc_match  = lyc_match_q;
  assign vblank_int = vblank_int_q;

endmodule

// File: doc/lcd_mode_ctrl.md
Name: lcd_mode_ctrl

Overview:
- Sequences the LCD dot and line timing: mode 2 (OAM search), mode 3 (transfer), mode 0 (hblank) and mode 1 (vblank).
- Generates LY, LYC compare, and the VBLANK/STAT interrupt pulses.
- Arbitrates VRAM and OAM between the CPU and the display fetch path; it drives the display module's oe_vram/oe_oam and the mode/lcd_v/interrupt inputs it exports.

Parameters:
DOTS_PER_LINE, 456, dots per scanline
LINES_PER_FRAME, 154, scanlines per frame (LY 0..153)
VISIBLE_LINES, 144, first vblank line index
OAM_DOTS, 80, mode-2 length in dots
XFER_DOTS, 172, mode-3 length in dots (fixed)

Ports:
clk  input  1  dot clock, one dot per cycle
rst  input  1  synchronous active-low reset
lcd_en  input  1  LCDC bit 7, LCD enable
lyc  input  8  LYC compare value
stat_ie  input  4  STAT enables: [0] hblank, [1] vblank, [2] oam, [3] lyc
cpu_vram_req  input  1  CPU requests VRAM
cpu_oam_req  input  1  CPU requests OAM
disp_vram_req  input  1  display fetch requests VRAM
disp_oam_req  input  1  display fetch requests OAM
cpu_vram_gnt  output  1  CPU VRAM access granted
cpu_oam_gnt  output  1  CPU OAM access granted
oe_vram  output  1  VRAM read enable to display fetch
oe_oam  output  1  OAM read enable to display fetch
mode  output  2  current LCD mode
lcd_v  output  8  LY, current line
lcd_x  output  9  dot within line, 0..455
lyc_match  output  1  lcd_v == lyc
vblank_int  output  1  one-cycle VBLANK interrupt pulse
lcdc_int  output  1  one-cycle STAT interrupt pulse

Behaviour:
- Reset (rst==0 at a clk edge), with rst taking priority over everything: lcd_x=0, lcd_v=0, mode=0, lyc_match=0, vblank_int=0, lcdc_int=0, all grants and oe outputs 0, internal STAT line 0.
- LCD disabled (lcd_en==0):
  - Counters held at 0, mode=0, no interrupts, oe_vram=oe_oam=0.
  - cpu_*_gnt = cpu_*_req.
  - The STAT line is forced to 0.
- LCD enable: the first cycle with lcd_en==1 shows lcd_x=0, lcd_v=0, mode=2. lcd_en falling mid-frame returns to the disabled state on the next edge, with no vblank_int pulse.
- Counting:
  - lcd_x increments every cycle. At DOTS_PER_LINE-1 it wraps to 0 and lcd_v increments.
  - lcd_v at 153 wraps to 0 together with the lcd_x wrap.
  - All counters and mode are registered.
- Mode, decoded from the next counter values and registered so mode aligns with lcd_x/lcd_v:
  - lcd_v ≥ 144 → 1.
  - Otherwise lcd_x < 80 → 2; lcd_x < 252 → 3; else → 0.
- vblank_int: high for exactly the one cycle in which lcd_v becomes 144 and lcd_x is 0.
- lyc_match: registered compare of the next lcd_v against lyc; it follows lyc changes within one cycle.
- STAT line = (ie[0]&mode==0) | (ie[1]&mode==1) | (ie[2]&mode==2) | (ie[3]&lyc_match).
  - lcdc_int pulses one cycle on the 0→1 edge only.
  - A line that stays high across a mode change produces no second pulse (STAT blocking).
- Arbitration (display has absolute priority in its windows; all grants are combinational from registered state):
  - OAM is locked to the display when mode is 2 or 3. cpu_oam_gnt = cpu_oam_req & ~lock_oam. oe_oam = disp_oam_req & lock_oam.
  - VRAM is locked when mode==3, and also at lcd_x==79 on visible lines (one-dot guard so an in-flight CPU access completes). cpu_vram_gnt = cpu_vram_req & ~lock_vram. oe_vram = disp_vram_req & lock_vram.
  - A CPU grant and the corresponding oe are never high in the same cycle.
- Display requests outside the lock windows are ignored (oe=0).

Decomposition:
- Shared package in constants.sv:
  - lcd_mode_t enum: MODE_HBLANK=2'd0, MODE_VBLANK=2'd1, MODE_OAM=2'd2, MODE_XFER=2'd3.
  - Localparams for dot and line timing.
  - STAT enable bit indices.
- Sub-module lcd_stat_irq: takes mode, lyc_match, stat_ie and enable; produces lcdc_int via the registered STAT line and rising-edge detect.
- Counter, mode decode and arbitration stay in lcd_mode_ctrl.

Test Plan:
- Reset then lcd_en=1 for 70224 cycles → mode sequence 2(80)/3(172)/0(204) per visible line; lines 144..153 mode 1; lcd_v wraps 153→0 exactly at cycle 70224.
- Free-run a full frame → vblank_int high for exactly 1 cycle, at lcd_v=144, lcd_x=0; no other pulses.
- lyc=8'd5, stat_ie=4'b1000 → one lcdc_int pulse when lcd_v becomes 5; with stat_ie=4'b1001 and lyc=line-of-hblank, no extra pulse while the line stays high.
- cpu_vram_req and disp_vram_req held high throughout → cpu_vram_gnt=0 for lcd_x 79..251 on lines 0..143 and high elsewhere; oe_vram is its exact complement; never both high.
- cpu_oam_req held high → cpu_oam_gnt=0 for lcd_x 0..251 on visible lines, 1 in hblank and vblank.
- Mid-frame events:
  - lcd_en drops at lcd_v=100 → next cycle lcd_v=0, mode=0, grants follow req.
  - rst low at lcd_v=50 with lcd_en=1 → next cycle all outputs at reset values.
